// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready output, frame-error pulse and sticky overrun flag
// Ports:
//   i_clk        single clock, all state changes on its rising edge
//   i_reset_n    synchronous active-low reset
//   i_uart_rx    asynchronous serial line, idle high, LSB first
//   o_data       received byte, stable while o_valid is high
//   o_valid      o_data holds an unconsumed byte
//   i_ready      consumer accepts the byte when o_valid is also high
//   o_busy       receiver is somewhere inside a frame
//   o_frame_err  one-cycle pulse when the stop bit samples low
//   o_overrun    sticky, set when a byte is dropped because o_data was still unconsumed
//   i_clr_err    clears o_overrun; a simultaneous overrun wins
module uart_rx #(
  parameter int CLKS_PER_BIT = 64
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clr_err
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  state_t      state;
  logic [15:0] timer;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        rx_m, rx_s, brk;
  logic        full, half, deliver;
  assign full    = timer == FULL;
  assign half    = timer == HALF;
  // a good stop bit hands the assembled byte to the output stage this edge
  assign deliver = state == STOP && !brk && full && rx_s;
  assign o_busy  = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      timer       <= '0;
      idx         <= '0;
      shreg       <= '0;
      brk         <= 1'b0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      rx_m        <= i_uart_rx;
      rx_s        <= rx_m;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          timer <= '0;
        end
        // mid-start re-check rejects glitches shorter than half a bit
        START: if (half) begin
          timer <= '0;
          idx   <= '0;
          state <= rx_s ? IDLE : DATA;
        end else timer <= timer + 16'd1;
        DATA: if (full) begin
          shreg[idx] <= rx_s;
          timer      <= '0;
          idx        <= idx + 3'd1;
          if (idx == 3'd7) state <= STOP;
        end else timer <= timer + 16'd1;
        // brk marks a bad stop bit: hold here until the line returns high
        STOP: if (brk) begin
          if (rx_s) begin
            brk   <= 1'b0;
            state <= IDLE;
          end
        end else if (full) begin
          timer <= '0;
          if (rx_s) state <= IDLE;
          else begin
            brk         <= 1'b1;
            o_frame_err <= 1'b1;
          end
        end else timer <= timer + 16'd1;
        default: state <= IDLE;
      endcase
      // a byte may land in the same cycle the previous one is consumed
      if (deliver && (!o_valid || i_ready)) begin
        o_data  <= shreg;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) o_valid <= 1'b0;
      if (deliver && o_valid && !i_ready) o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;
    end
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 64, meaning clock cycles per bit (7.37 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port i_uart_rx, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port o_data, output, 8, received byte.
REQ-006 SHALL have port o_valid, output, 1, o_data holds an unconsumed byte.
REQ-007 SHALL have port i_ready, input, 1, consumer accepts the byte; a transfer occurs when o_valid and i_ready are both 1.
REQ-008 SHALL have port o_busy, output, 1, high in any state other than IDLE.
REQ-009 SHALL have port o_frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port o_overrun, output, 1, sticky flag for a lost byte.
REQ-011 SHALL have port i_clr_err, input, 1, clears o_overrun.

Function
REQ-012 SHALL pass i_uart_rx through a 2-flop synchronizer; both flops reset to 1; all decoding uses the second flop (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, STOP with a 16-bit bit-timer and a 3-bit bit index.
REQ-014 IDLE: on rx_s==0, SHALL go to START and clear the timer.
REQ-015 START: at timer==CLKS_PER_BIT/2-1 (integer divide), SHALL sample rx_s; 1 -> IDLE (false start, no flag); 0 -> DATA with the timer cleared and the index at 0.
REQ-016 DATA: at each timer==CLKS_PER_BIT-1, SHALL sample rx_s into the shift register at position index, clear the timer, and increment the index; after the sample at index 7 it SHALL go to STOP.
REQ-017 STOP: at timer==CLKS_PER_BIT-1, SHALL sample rx_s.
  - 1: deliver the byte and go to IDLE.
  - 0: pulse o_frame_err for exactly 1 cycle, discard the byte, and stay in STOP until rx_s==1, then go to IDLE.
REQ-018 Delivery SHALL load o_data and set o_valid on the clock edge following the stop sample; latency from the start-bit falling edge on i_uart_rx to o_valid is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, within 1.
REQ-019 o_data SHALL remain stable while o_valid==1; o_valid SHALL clear on the cycle after a transfer.
REQ-020 Delivery while o_valid==1 without i_ready SHALL keep the old o_data, drop the new byte, and set o_overrun.
REQ-021 Delivery in the same cycle as a transfer SHALL load the new byte, keep o_valid at 1, and not set o_overrun.
REQ-022 i_clr_err SHALL clear o_overrun next cycle; if an overrun occurs in the same cycle, the set SHALL win.
REQ-023 The receiver SHALL keep receiving regardless of o_valid; there is no backpressure on the line.
REQ-024 Arithmetic SHALL be unsigned; the timer SHALL never wrap, because it is cleared at every compare match.

Reset
REQ-025 While i_reset_n==0 at a clock edge, the block SHALL set:
  - state IDLE, timer 0, index 0
  - o_data 8'h00, o_valid 0, o_busy 0, o_frame_err 0, o_overrun 0
  - synchronizer flops 1
REQ-026 Reset asserted mid-frame SHALL abort the frame with no delivery and no flags; after release the block waits in IDLE for the next falling edge.
REQ-027 If the line is low when reset is released, the block SHALL treat it as a start candidate, and REQ-015 and REQ-017 SHALL govern recovery.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 8'hA5 with i_ready held at 1 -> o_data=8'hA5 and o_valid high for 1 cycle, about 154 cycles after the falling edge; o_frame_err=0, o_overrun=0.
REQ-029 Send a 5-cycle low glitch on an idle line -> no o_valid, no o_frame_err; o_busy returns to 0 by cycle 10.
REQ-030 Send 8'h3C with the stop bit forced to 0 for 40 cycles -> one o_frame_err pulse, o_valid stays 0, state is IDLE once the line is high; then send 8'h01 -> received correctly.
REQ-031 With i_ready=0, send 8'h11 then 8'h22 back-to-back -> o_data=8'h11 stays valid and o_overrun=1; pulse i_clr_err -> o_overrun=0.
REQ-032 Hold i_ready=0, send 8'h55, and raise i_ready exactly on the 8'h66 delivery cycle -> o_data=8'h66, o_valid stays 1, o_overrun=0.
REQ-033 Assert reset during bit 4 of 8'hFF, release, then send 8'h0F -> only 8'h0F is delivered, with no flags.
